// File: rtl/time_setter.sv
// Hours/minutes setting front-end for the centisecond clock: debounced mode/inc
// buttons drive a RUN -> EDIT_H -> EDIT_M -> COMMIT editor with an idle timeout.
module time_setter #(
   parameter int unsigned DB_CYCLES      = 5,
   parameter int unsigned TIMEOUT_CYCLES = 3000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   output logic [4:0] set_hours,
   output logic [5:0] set_minutes,
   output logic       load,
   output logic [1:0] field
);

   localparam logic [3:0]  DB_LAST   = 4'(DB_CYCLES - 1);
   localparam logic [11:0] IDLE_LAST = 12'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_HRS  = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;

   typedef enum logic [1:0] {RUN, EDIT_H, EDIT_M, COMMIT} state_e;

   // Bit 0 is the mode button, bit 1 the increment button.
   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      db_q, db_d;
   logic [1:0]      press_q, press_d;
   logic [1:0][3:0] db_cnt_q, db_cnt_d;

   assign btn_raw = {btn_inc, btn_mode};

   // The counter only runs while the synced level disagrees with the accepted
   // level; the accepting cycle also emits the one-cycle press on a rising level.
   always_comb begin
      db_d     = db_q;
      press_d  = '0;
      db_cnt_d = '0;
      for (int unsigned b = 0; b < 2; b++) begin
         if (sync2_q[b] != db_q[b]) begin
            if (db_cnt_q[b] == DB_LAST) begin
               db_d[b]    = sync2_q[b];
               press_d[b] = sync2_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         press_q  <= '0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   logic mode_ev, inc_ev;
   assign mode_ev = press_q[0];
   assign inc_ev  = press_q[1];

   state_e      state_q;
   logic [4:0]  set_hours_q;
   logic [5:0]  set_minutes_q;
   logic        load_q;
   logic [1:0]  field_q;
   logic [11:0] idle_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         set_hours_q   <= '0;
         set_minutes_q <= '0;
         load_q        <= 1'b0;
         field_q       <= FIELD_NONE;
         idle_q        <= '0;
      end else begin
         load_q <= 1'b0;
         case (state_q)
            RUN: begin
               field_q <= FIELD_NONE;
               idle_q  <= '0;
               if (mode_ev) begin
                  state_q       <= EDIT_H;
                  field_q       <= FIELD_HRS;
                  set_hours_q   <= (cur_hours > 5'd23)   ? '0 : cur_hours;
                  set_minutes_q <= (cur_minutes > 6'd59) ? '0 : cur_minutes;
               end
            end
            EDIT_H: begin
               if (mode_ev) begin
                  state_q <= EDIT_M;
                  field_q <= FIELD_MIN;
                  idle_q  <= '0;
               end else if (inc_ev) begin
                  set_hours_q <= (set_hours_q == 5'd23) ? '0 : set_hours_q + 5'd1;
                  idle_q      <= '0;
               end else if (idle_q == IDLE_LAST) begin
                  state_q <= RUN;
                  field_q <= FIELD_NONE;
                  idle_q  <= '0;
               end else begin
                  idle_q <= idle_q + 12'd1;
               end
            end
            EDIT_M: begin
               if (mode_ev) begin
                  state_q <= COMMIT;
                  field_q <= FIELD_NONE;
                  load_q  <= 1'b1;
                  idle_q  <= '0;
               end else if (inc_ev) begin
                  set_minutes_q <= (set_minutes_q == 6'd59) ? '0 : set_minutes_q + 6'd1;
                  idle_q        <= '0;
               end else if (idle_q == IDLE_LAST) begin
                  state_q <= RUN;
                  field_q <= FIELD_NONE;
                  idle_q  <= '0;
               end else begin
                  idle_q <= idle_q + 12'd1;
               end
            end
            COMMIT: begin
               state_q <= RUN;
               field_q <= FIELD_NONE;
               idle_q  <= '0;
            end
            default: begin
               state_q <= RUN;
               field_q <= FIELD_NONE;
               idle_q  <= '0;
            end
         endcase
      end
   end

   assign set_hours   = set_hours_q;
   assign set_minutes = set_minutes_q;
   assign load        = load_q;
   assign field       = field_q;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: debounce latency, edit/wrap, clamp, priority,
// timeout and asynchronous reset behaviour with default parameters.
module tb_time_setter;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode, btn_inc;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [4:0] set_hours;
   logic [5:0] set_minutes;
   logic       load;
   logic [1:0] field;

   int n_checks = 0;
   int n_pass   = 0;
   int load_cnt = 0;
   int load_consec = 0;
   logic load_prev = 1'b0;

   time_setter #(.DB_CYCLES(5), .TIMEOUT_CYCLES(3000)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .cur_hours  (cur_hours),
      .cur_minutes(cur_minutes),
      .set_hours  (set_hours),
      .set_minutes(set_minutes),
      .load       (load),
      .field      (field)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (load === 1'b1) begin
         load_cnt++;
         if (load_prev === 1'b1) load_consec++;
      end
      load_prev = load;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Hold the buttons until one cycle after the press event, then let go.
   task automatic press(input logic m, input logic i);
      @(negedge clk);
      btn_mode = m;
      btn_inc  = i;
      repeat (8) @(posedge clk);
      #1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   task automatic settle();
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      cur_hours = 5'd13; cur_minutes = 6'd45;
      #1;
      check("rst_field", field, 0);
      check("rst_load", load, 0);
      check("rst_hours", set_hours, 0);
      check("rst_minutes", set_minutes, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_field", field, 0);
      @(negedge clk);
      rst = 1'b1;

      // Bounce for 10 cycles, then hold high.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         btn_mode = (k % 2 == 0);
      end
      @(negedge clk);
      btn_mode = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("bounce_field_before", field, 0);
      @(posedge clk);
      #1;
      check("bounce_field_after", field, 1);
      check("capture_hours", set_hours, 13);
      check("capture_minutes", set_minutes, 45);
      repeat (20) @(posedge clk);
      #1;
      check("bounce_single_event", field, 1);
      btn_mode = 1'b0;
      settle();

      // Full edit: hours 13 -> 23 -> 0, minutes 45 -> 59 -> 0.
      for (int k = 0; k < 10; k++) begin press(1'b0, 1'b1); settle(); end
      check("hours_at_23", set_hours, 23);
      press(1'b0, 1'b1); settle();
      check("hours_wrap", set_hours, 0);
      check("edit_h_field", field, 1);
      press(1'b1, 1'b0); settle();
      check("edit_m_field", field, 2);
      for (int k = 0; k < 14; k++) begin press(1'b0, 1'b1); settle(); end
      check("minutes_at_59", set_minutes, 59);
      press(1'b0, 1'b1); settle();
      check("minutes_wrap", set_minutes, 0);
      check("minutes_no_carry", set_hours, 0);
      press(1'b1, 1'b0);
      check("commit_load", load, 1);
      check("commit_field", field, 0);
      @(posedge clk);
      #1;
      check("commit_load_drop", load, 0);
      check("run_field", field, 0);
      settle();

      // Inc in RUN is ignored.
      press(1'b0, 1'b1); settle();
      check("run_inc_field", field, 0);
      check("run_inc_hours", set_hours, 0);

      // Clamp out-of-range capture.
      cur_hours = 5'd27; cur_minutes = 6'd63;
      press(1'b1, 1'b0); settle();
      check("clamp_field", field, 1);
      check("clamp_hours", set_hours, 0);
      check("clamp_minutes", set_minutes, 0);
      press(1'b0, 1'b1); settle();
      press(1'b0, 1'b1); settle();
      check("hours_two", set_hours, 2);

      // Simultaneous mode+inc: mode wins.
      press(1'b1, 1'b1); settle();
      check("simul_field", field, 2);
      check("simul_hours", set_hours, 2);

      // Last press event, then 3000 idle cycles to timeout.
      press(1'b0, 1'b1); settle();
      check("minutes_one", set_minutes, 1);
      repeat (2991) @(posedge clk);
      #1;
      check("timeout_before", field, 2);
      @(posedge clk);
      #1;
      check("timeout_field", field, 0);
      check("timeout_hours", set_hours, 2);
      check("timeout_minutes", set_minutes, 1);
      check("timeout_no_load", load_cnt, 1);

      // Reset in EDIT_M, with mode held across reset release.
      cur_hours = 5'd10; cur_minutes = 6'd30;
      press(1'b1, 1'b0); settle();
      press(1'b1, 1'b0); settle();
      check("pre_reset_field", field, 2);
      check("pre_reset_minutes", set_minutes, 30);
      @(posedge clk);
      #2;
      rst = 1'b0;
      btn_mode = 1'b1;
      #1;
      check("async_rst_field", field, 0);
      check("async_rst_minutes", set_minutes, 0);
      check("async_rst_load", load, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_held_hours", set_hours, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("post_rst_before", field, 0);
      @(posedge clk);
      #1;
      check("post_rst_press", field, 1);
      check("post_rst_hours", set_hours, 10);
      btn_mode = 1'b0;
      settle();

      // Second commit, then capture of the largest legal time.
      press(1'b1, 1'b0); settle();
      press(1'b1, 1'b0);
      check("commit2_load", load, 1);
      settle();
      cur_hours = 5'd23; cur_minutes = 6'd59;
      press(1'b1, 1'b0); settle();
      check("max_hours", set_hours, 23);
      check("max_minutes", set_minutes, 59);

      check("load_total", load_cnt, 2);
      check("load_consecutive", load_consec, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
